// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle around a pipe_stage_skid: upstream (in_*) and downstream (out_*) sides.
// slave is the stage's view; master is the view of the logic surrounding the stage.
interface pipe_stage_skid_if #(
    parameter int unsigned DW = 32
);
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, flush with NOP injection and hold_flag stall.
// Optional perf counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
    parameter int unsigned     DW         = 32,
    parameter logic [DW-1:0]   NOP_VAL    = DW'(32'h00000013),
    parameter int unsigned     HFW        = 3,
    parameter logic [HFW-1:0]  HOLD_LEVEL = HFW'(2)
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_stage_skid_if.slave      hs_io,
    input  logic                  flush_i,
    input  logic [HFW-1:0]        hold_flag_i,
    output logic [1:0]            occupancy_o,
    output logic [31:0]           stall_cnt_o,
    output logic [15:0]           flush_cnt_o
);

    logic          m_valid_q, m_valid_d;
    logic [DW-1:0] m_data_q,  m_data_d;
    logic          s_valid_q, s_valid_d;
    logic [DW-1:0] s_data_q,  s_data_d;

    logic stall;
    logic eff_ready;
    logic acc;
    logic drn;

    assign stall     = (hold_flag_i >= HOLD_LEVEL);
    assign eff_ready = hs_io.out_ready_i & ~stall;
    assign acc       = hs_io.in_valid_i & ~s_valid_q;
    assign drn       = m_valid_q & eff_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (flush_i) begin
            m_valid_d = 1'b0;
            m_data_d  = NOP_VAL;
            s_valid_d = 1'b0;
            s_data_d  = NOP_VAL;
        end else if (!m_valid_q || drn) begin
            if (s_valid_q) begin
                // Skid entry is older than anything upstream, so it moves first.
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                s_valid_d = acc;
                s_data_d  = acc ? hs_io.in_data_i : NOP_VAL;
            end else if (acc) begin
                m_valid_d = 1'b1;
                m_data_d  = hs_io.in_data_i;
            end else begin
                m_valid_d = 1'b0;
                m_data_d  = NOP_VAL;
            end
        end else if (acc) begin
            s_valid_d = 1'b1;
            s_data_d  = hs_io.in_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= NOP_VAL;
            s_valid_q <= 1'b0;
            s_data_q  <= NOP_VAL;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
        end
    end

    // in_ready depends only on registered state, breaking any ready chain through the stage.
    assign hs_io.in_ready_o  = ~s_valid_q;
    assign hs_io.out_valid_o = m_valid_q;
    assign hs_io.out_data_o  = m_data_q;
    assign occupancy_o       = {1'b0, m_valid_q} + {1'b0, s_valid_q};

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (m_valid_q && !eff_ready && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_i && (flush_cnt_q != 16'hFFFF))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed checks on a 32-bit stage, then a randomized FIFO-scoreboard run on an 8-bit stage.
module tb_pipe_stage_skid;

`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_a, flush_b;
    logic [2:0]  hold_a, hold_b;
    logic [1:0]  occ_a, occ_b;
    logic [31:0] stall_a, stall_b;
    logic [15:0] fcnt_a, fcnt_b;

    int checks   = 0;
    int failures = 0;

    pipe_stage_skid_if #(.DW(32)) bus_a ();
    pipe_stage_skid_if #(.DW(8))  bus_b ();

    pipe_stage_skid #(.DW(32), .HFW(3), .HOLD_LEVEL(3'd2)) dut_a (
        .clk(clk), .rst(rst), .hs_io(bus_a), .flush_i(flush_a), .hold_flag_i(hold_a),
        .occupancy_o(occ_a), .stall_cnt_o(stall_a), .flush_cnt_o(fcnt_a)
    );

    pipe_stage_skid #(.DW(8), .HFW(3), .HOLD_LEVEL(3'd1)) dut_b (
        .clk(clk), .rst(rst), .hs_io(bus_b), .flush_i(flush_b), .hold_flag_i(hold_b),
        .occupancy_o(occ_b), .stall_cnt_o(stall_b), .flush_cnt_o(fcnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [31:0] d,
                         input logic r, input logic [1:0] o);
        chk({tag, ".valid"}, {63'd0, bus_a.out_valid_o}, {63'd0, v});
        chk({tag, ".data"},  {32'd0, bus_a.out_data_o},  {32'd0, d});
        chk({tag, ".ready"}, {63'd0, bus_a.in_ready_o},  {63'd0, r});
        chk({tag, ".occ"},   {62'd0, occ_a},             {62'd0, o});
        $display("step %s: valid=%0b data=%0h ready=%0b occ=%0d", tag,
                 bus_a.out_valid_o, bus_a.out_data_o, bus_a.in_ready_o, occ_a);
    endtask

    logic [7:0] q[$];
    logic       exp_v, exp_r, acc_m, drn_m;
    logic [7:0] exp_d;

    initial begin
        rst = 1'b1;
        flush_a = 1'b0; hold_a = 3'd0;
        bus_a.in_valid_i = 1'b0; bus_a.in_data_i = 32'd0; bus_a.out_ready_i = 1'b0;
        flush_b = 1'b0; hold_b = 3'd0;
        bus_b.in_valid_i = 1'b0; bus_b.in_data_i = 8'd0; bus_b.out_ready_i = 1'b0;
        tick(); tick();
        chk_a("reset", 1'b0, 32'h13, 1'b1, 2'd0);
        chk("reset.stall_cnt", {32'd0, stall_a}, 64'd0);
        chk("reset.flush_cnt", {48'd0, fcnt_a}, 64'd0);
        rst = 1'b0;

        // Streaming at full throughput
        bus_a.out_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus_a.in_valid_i = 1'b1;
            bus_a.in_data_i  = 32'h100 + i;
            tick();
            chk_a($sformatf("stream%0d", i), 1'b1, 32'h100 + i, 1'b1, 2'd1);
        end
        bus_a.in_valid_i = 1'b0;
        tick();
        chk_a("stream_end", 1'b0, 32'h13, 1'b1, 2'd0);

        // Back-pressure into the skid entry
        bus_a.out_ready_i = 1'b0;
        bus_a.in_valid_i = 1'b1; bus_a.in_data_i = 32'hA1;
        tick();
        chk_a("skid_a1", 1'b1, 32'hA1, 1'b1, 2'd1);
        bus_a.in_data_i = 32'hA2;
        tick();
        chk_a("skid_a2", 1'b1, 32'hA1, 1'b0, 2'd2);
        bus_a.in_data_i = 32'hA3;
        tick();
        chk_a("skid_full", 1'b1, 32'hA1, 1'b0, 2'd2);
        bus_a.in_valid_i = 1'b0; bus_a.out_ready_i = 1'b1;
        tick();
        chk_a("skid_out_a2", 1'b1, 32'hA2, 1'b1, 2'd1);
        tick();
        chk_a("skid_empty", 1'b0, 32'h13, 1'b1, 2'd0);

        // Asynchronous reset with two entries held
        bus_a.out_ready_i = 1'b0;
        bus_a.in_valid_i = 1'b1; bus_a.in_data_i = 32'hC1;
        tick();
        bus_a.in_data_i = 32'hC2;
        tick();
        chk_a("pre_rst", 1'b1, 32'hC1, 1'b0, 2'd2);
        bus_a.in_valid_i = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk_a("async_rst", 1'b0, 32'h13, 1'b1, 2'd0);
        chk("async_rst.stall_cnt", {32'd0, stall_a}, 64'd0);
        tick();
        rst = 1'b0;

        // Hold-flag stall with upstream filling the skid entry
        bus_a.out_ready_i = 1'b1; hold_a = 3'd0;
        bus_a.in_valid_i = 1'b1; bus_a.in_data_i = 32'hB1;
        tick();
        chk_a("stall_fill", 1'b1, 32'hB1, 1'b1, 2'd1);
        hold_a = 3'd3; bus_a.in_data_i = 32'hB2;
        tick();
        chk_a("stall1", 1'b1, 32'hB1, 1'b0, 2'd2);
        bus_a.in_data_i = 32'hB3;
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk_a($sformatf("stall%0d", i), 1'b1, 32'hB1, 1'b0, 2'd2);
        end
        chk("stall.stall_cnt", {32'd0, stall_a}, PERF ? 64'd4 : 64'd0);
        hold_a = 3'd1; bus_a.in_valid_i = 1'b0;
        tick();
        chk_a("unstall_b2", 1'b1, 32'hB2, 1'b1, 2'd1);
        tick();
        chk_a("unstall_empty", 1'b0, 32'h13, 1'b1, 2'd0);
        chk("unstall.stall_cnt", {32'd0, stall_a}, PERF ? 64'd4 : 64'd0);

        // Flush with two entries held and a payload offered
        hold_a = 3'd0; bus_a.out_ready_i = 1'b0;
        bus_a.in_valid_i = 1'b1; bus_a.in_data_i = 32'hD1;
        tick();
        bus_a.in_data_i = 32'hD2;
        tick();
        chk_a("pre_flush", 1'b1, 32'hD1, 1'b0, 2'd2);
        flush_a = 1'b1; bus_a.in_data_i = 32'hFF;
        tick();
        chk_a("flush", 1'b0, 32'h13, 1'b1, 2'd0);
        chk("flush.flush_cnt", {48'd0, fcnt_a}, PERF ? 64'd1 : 64'd0);
        flush_a = 1'b0; bus_a.in_valid_i = 1'b0; bus_a.out_ready_i = 1'b1;
        tick();
        chk_a("post_flush", 1'b0, 32'h13, 1'b1, 2'd0);

        // Flush discards a same-cycle acceptance
        bus_a.out_ready_i = 1'b0;
        bus_a.in_valid_i = 1'b1; bus_a.in_data_i = 32'hE1;
        tick();
        flush_a = 1'b1; bus_a.in_data_i = 32'hEE;
        tick();
        chk_a("flush_acc", 1'b0, 32'h13, 1'b1, 2'd0);
        flush_a = 1'b0; bus_a.in_valid_i = 1'b0; bus_a.out_ready_i = 1'b1;
        tick();
        chk_a("flush_acc_after", 1'b0, 32'h13, 1'b1, 2'd0);
        chk("flush2.flush_cnt", {48'd0, fcnt_a}, PERF ? 64'd2 : 64'd0);

        // Randomized run on the 8-bit stage against a FIFO scoreboard
        for (int n = 0; n < 10000; n++) begin
            exp_v = (q.size() != 0);
            exp_d = (q.size() != 0) ? q[0] : 8'h13;
            exp_r = (q.size() < 2);
            assert (bus_b.out_valid_o === exp_v && bus_b.out_data_o === exp_d &&
                    bus_b.in_ready_o === exp_r && occ_b === 2'(q.size()) && occ_b <= 2'd2)
            else begin
                failures++;
                $error("FAIL rand%0d observed=v%0b d%0h r%0b o%0d expected=v%0b d%0h r%0b o%0d",
                       n, bus_b.out_valid_o, bus_b.out_data_o, bus_b.in_ready_o, occ_b,
                       exp_v, exp_d, exp_r, q.size());
            end
            checks++;
            bus_b.in_valid_i  = 1'($urandom_range(0, 1));
            bus_b.in_data_i   = 8'($urandom);
            bus_b.out_ready_i = ($urandom_range(0, 3) != 0);
            hold_b  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            flush_b = ($urandom_range(0, 99) == 0);
            acc_m = bus_b.in_valid_i && (q.size() < 2);
            drn_m = (q.size() != 0) && bus_b.out_ready_i && (hold_b < 3'd1);
            if (flush_b) begin
                q.delete();
            end else begin
                if (drn_m) void'(q.pop_front());
                if (acc_m) q.push_back(bus_b.in_data_i);
            end
            tick();
        end
        $display("step random: 10000 cycles compared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
